pc_select_unit: RTL and testbench

- Parametrised next-PC unit for the multi-cycle core, successor to the fixed 3-input PC select mux.
- Owns the PC register and selects the next PC from NUM_SRC sources: source 0 is the sequential PC+INC, computed internally.
- Buffers one redirect arriving while the PC write strobe is low, so a branch or jump target is never lost across stall cycles.
- Traps illegal selects and misaligned targets to TRAP_VEC and reports them through sticky error flags.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_target_resolve.sv | 70 +++++++
 rtl/pc_select_unit.sv | 138 +++++++++++++
 tb/tb_pc_select_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants and the PC source enumeration for the
//                next-PC unit and the control FSM that drives its select.
//  Contents    : PC_XLEN, PC_INC, PC_RESET_VEC, PC_TRAP_VEC, PC_ALIGN_BITS,
//                pc_sel_e (PC_SEQ=0, PC_BRANCH=1, PC_JUMP=2, PC_JREG=3)
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int          PC_XLEN       = 32;
    localparam int          PC_INC        = 4;
    localparam int          PC_ALIGN_BITS = 2;
    localparam logic [31:0] PC_RESET_VEC  = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC   = 32'h0000_0100;

    // Source index encoding used by the control FSM; index 0 is always the
    // internally generated sequential PC.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JREG   = 2'd3
    } pc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_target_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : pc_target_resolve
//  Description : Combinational next-PC target selection with illegal-select
//                and misaligned-target trapping.
//  Ports       : sel_valid  - a live redirect is presented
//                pc_sel     - source index
//                src_in     - flattened external targets (slice 0 unused)
//                pc_seq     - sequential PC, used as source 0
//                target     - resolved target (TRAP_VEC on any error)
//                illegal    - pc_sel >= NUM_SRC on a live redirect
//                misalign   - raw target misaligned on a live redirect
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_target_resolve
    import pc_pkg::*;
#(
    parameter int          XLEN       = PC_XLEN,
    parameter int          NUM_SRC    = 4,
    parameter int          SEL_W      = $clog2(NUM_SRC),
    parameter int          ALIGN_BITS = PC_ALIGN_BITS,
    parameter logic [XLEN-1:0] TRAP_VEC = PC_TRAP_VEC
) (
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        pc_sel,
    input  logic [NUM_SRC*XLEN-1:0] src_in,
    input  logic [XLEN-1:0]         pc_seq,
    output logic [XLEN-1:0]         target,
    output logic                    illegal,
    output logic                    misalign
);

    logic [XLEN-1:0] w_raw;
    logic            w_hit;
    logic            w_raw_misaligned;
    logic            w_unused_src0;

    // Slice 0 position is occupied by the internal sequential PC.
    assign w_unused_src0 = ^src_in[XLEN-1:0];

    always_comb begin
        w_raw = TRAP_VEC;
        w_hit = 1'b0;
        if (pc_sel == SEL_W'(PC_SEQ)) begin
            w_raw = pc_seq;
            w_hit = 1'b1;
        end
        for (int i = 1; i < NUM_SRC; i++) begin
            if (pc_sel == SEL_W'(i)) begin
                w_raw = src_in[i*XLEN +: XLEN];
                w_hit = 1'b1;
            end
        end
    end

    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign w_raw_misaligned = |w_raw[ALIGN_BITS-1:0];
        end else begin : g_no_align_chk
            assign w_raw_misaligned = 1'b0;
        end
    endgenerate

    // Flags only mean something when a redirect is actually presented.
    assign illegal  = sel_valid & ~w_hit;
    assign misalign = sel_valid & w_hit & w_raw_misaligned;
    assign target   = (w_hit && !w_raw_misaligned) ? w_raw : TRAP_VEC;

endmodule : pc_target_resolve
`default_nettype wire

// File: rtl/pc_select_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_select_unit
//  Description : PC register and next-PC selection with a one-entry redirect
//                buffer that survives stall cycles, plus sticky trap flags.
//  Ports       : clk, rst_n (async active-low)
//                pc_we         - PC write strobe
//                sel_valid     - redirect present on pc_sel/src_in
//                pc_sel        - source index (0 = pc + INC)
//                src_in        - flattened source targets
//                err_clr       - clears sticky flags
//                pc            - current PC (registered)
//                pc_seq        - pc + INC (combinational)
//                pend_valid    - a buffered redirect is held
//                redirect_drop - pulse: held redirect overwritten
//                illegal_sel   - sticky illegal select flag
//                misalign_err  - sticky misaligned target flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_select_unit
    import pc_pkg::*;
#(
    parameter int              XLEN       = PC_XLEN,
    parameter int              NUM_SRC    = 4,
    parameter int              SEL_W      = $clog2(NUM_SRC),
    parameter int              INC        = PC_INC,
    parameter int              ALIGN_BITS = PC_ALIGN_BITS,
    parameter logic [XLEN-1:0] RESET_VEC  = PC_RESET_VEC,
    parameter logic [XLEN-1:0] TRAP_VEC   = PC_TRAP_VEC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pc_we,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        pc_sel,
    input  logic [NUM_SRC*XLEN-1:0] src_in,
    input  logic                    err_clr,
    output logic [XLEN-1:0]         pc,
    output logic [XLEN-1:0]         pc_seq,
    output logic                    pend_valid,
    output logic                    redirect_drop,
    output logic                    illegal_sel,
    output logic                    misalign_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    logic [0:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_buf_tgt;
    logic            r_buf_ill;
    logic            r_buf_mis;
    logic            r_drop;
    logic            r_ill;
    logic            r_mis;

    logic [XLEN-1:0] w_tgt;
    logic            w_ill;
    logic            w_mis;
    logic            w_held;
    logic [XLEN-1:0] w_next_pc;
    logic            w_set_ill;
    logic            w_set_mis;

    assign pc_seq = r_pc + XLEN'(INC);

    pc_target_resolve #(
        .XLEN       (XLEN),
        .NUM_SRC    (NUM_SRC),
        .SEL_W      (SEL_W),
        .ALIGN_BITS (ALIGN_BITS),
        .TRAP_VEC   (TRAP_VEC)
    ) u_resolve (
        .sel_valid (sel_valid),
        .pc_sel    (pc_sel),
        .src_in    (src_in),
        .pc_seq    (pc_seq),
        .target    (w_tgt),
        .illegal   (w_ill),
        .misalign  (w_mis)
    );

    assign w_held = (r_state == S_HELD);

    // A live redirect always beats the buffered one; with neither, step.
    always_comb begin
        w_next_pc = pc_seq;
        w_set_ill = 1'b0;
        w_set_mis = 1'b0;
        if (sel_valid) begin
            w_next_pc = w_tgt;
            w_set_ill = pc_we & w_ill;
            w_set_mis = pc_we & w_mis;
        end else if (w_held) begin
            w_next_pc = r_buf_tgt;
            w_set_ill = pc_we & r_buf_ill;
            w_set_mis = pc_we & r_buf_mis;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_VEC;
            r_buf_tgt <= '0;
            r_buf_ill <= 1'b0;
            r_buf_mis <= 1'b0;
            r_drop    <= 1'b0;
            r_ill     <= 1'b0;
            r_mis     <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            // Setting has priority over clearing on the same cycle.
            r_ill  <= w_set_ill | (r_ill & ~err_clr);
            r_mis  <= w_set_mis | (r_mis & ~err_clr);

            if (pc_we) begin
                r_pc    <= w_next_pc;
                r_state <= S_IDLE;
            end else if (sel_valid) begin
                r_buf_tgt <= w_tgt;
                r_buf_ill <= w_ill;
                r_buf_mis <= w_mis;
                r_state   <= S_HELD;
                r_drop    <= w_held;
            end
        end
    end

    assign pc            = r_pc;
    assign pend_valid    = w_held;
    assign redirect_drop = r_drop;
    assign illegal_sel   = r_ill;
    assign misalign_err  = r_mis;

endmodule : pc_select_unit
`default_nettype wire

// File: tb/tb_pc_select_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_select_unit
//  Description : Directed, table-driven bench for pc_select_unit (NUM_SRC=3)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_select_unit;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    pc_we;
    logic                    sel_valid;
    logic [SEL_W-1:0]        pc_sel;
    logic [NUM_SRC*XLEN-1:0] src_in;
    logic                    err_clr;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         pc_seq;
    logic                    pend_valid;
    logic                    redirect_drop;
    logic                    illegal_sel;
    logic                    misalign_err;

    int checks;
    int errors;

    pc_select_unit #(
        .XLEN       (XLEN),
        .NUM_SRC    (NUM_SRC),
        .SEL_W      (SEL_W),
        .INC        (4),
        .ALIGN_BITS (2),
        .RESET_VEC  (32'h0000_0000),
        .TRAP_VEC   (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_we         (pc_we),
        .sel_valid     (sel_valid),
        .pc_sel        (pc_sel),
        .src_in        (src_in),
        .err_clr       (err_clr),
        .pc            (pc),
        .pc_seq        (pc_seq),
        .pend_valid    (pend_valid),
        .redirect_drop (redirect_drop),
        .illegal_sel   (illegal_sel),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        sv;
        logic [1:0]  sel;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        clr;
        logic [31:0] e_pc;
        logic        e_pend;
        logic        e_drop;
        logic        e_ill;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, " pc"},       pc,                   v.e_pc);
        check({tag, " pc_seq"},   pc_seq,               v.e_pc + 32'd4);
        check({tag, " pend"},     {31'd0, pend_valid},    {31'd0, v.e_pend});
        check({tag, " drop"},     {31'd0, redirect_drop}, {31'd0, v.e_drop});
        check({tag, " ill"},      {31'd0, illegal_sel},   {31'd0, v.e_ill});
        check({tag, " mis"},      {31'd0, misalign_err},  {31'd0, v.e_mis});
    endtask

    task automatic drive(input vec_t v);
        pc_we     = v.we;
        sel_valid = v.sv;
        pc_sel    = v.sel;
        err_clr   = v.clr;
        src_in    = {v.s2, v.s1, 32'hDEAD_BEEF};
    endtask

    function automatic vec_t mk(input logic we, input logic sv, input logic [1:0] sel,
                                input logic [31:0] s1, input logic [31:0] s2, input logic clr,
                                input logic [31:0] e_pc, input logic e_pend, input logic e_drop,
                                input logic e_ill, input logic e_mis);
        vec_t v;
        v.we = we; v.sv = sv; v.sel = sel; v.s1 = s1; v.s2 = s2; v.clr = clr;
        v.e_pc = e_pc; v.e_pend = e_pend; v.e_drop = e_drop; v.e_ill = e_ill; v.e_mis = e_mis;
        return v;
    endfunction

    initial begin
        vec_t idle_v;
        checks = 0;
        errors = 0;

        //             we sv sel s1            s2         clr  pc            pend drop ill mis
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h4,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h8,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'hC,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h40,       0,         0, 32'hC,        1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h40,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h40,       0,         0, 32'h40,       1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0,            32'h80,    0, 32'h40,       1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h80,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h40,       0,         0, 32'h80,       1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 0,            32'h90,    0, 32'h90,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0,         0, 32'h90,       0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 0,            0,         0, 32'h100,      0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 32'h42,       0,         0, 32'h100,      0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,         1, 32'h100,      0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h46,       0,         0, 32'h100,      1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h100,      0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 3, 0,            0,         1, 32'h100,      0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h104,      0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0,         1, 32'h104,      0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0,            32'h200,   0, 32'h104,      1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0,         0, 32'h104,      1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h200,      0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,            0,         0, 32'h204,      0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'hFFFF_FFFC, 0,        0, 32'hFFFF_FFFC, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0,         0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h300,      0,         0, 32'h0,        1, 0, 0, 0));

        idle_v = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(idle_v);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all(0, idle_v);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check_all(i + 1, vecs[i]);
        end

        // Async reset while a redirect is held, between clock edges.
        check("pre-reset pend", {31'd0, pend_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst pc",   pc,                      32'h0);
        check("async rst pend", {31'd0, pend_valid},     32'd0);
        drive(idle_v);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst idle pc",   pc,                  32'h0);
        check("post-rst idle pend", {31'd0, pend_valid}, 32'd0);
        pc_we = 1'b1;
        @(negedge clk);
        check("post-rst step pc",   pc,                  32'h4);
        check("post-rst step pend", {31'd0, pend_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_select_unit
`default_nettype wire
